temp_monitor: RTL and testbench
===============================

Name: temp_monitor

Overview:
- Downstream consumer of the temp_to_dig converter output.
- Block-averages the 8-bit temperature samples.
- Tracks min/max of the averages.
- Drives an over-temperature alarm with hysteresis and a persistence filter.
- Its outputs feed the chip's status and readout logic.

Parameters:
WIDTH, 8, sample and threshold width in bits
AVG_LOG2, 2, log2 of samples per averaging window (window = 4)
ALARM_CNT, 3, consecutive window averages above thr_hi required to raise alarm (legal range 1..15)

Ports:
clk  in  1  system clock; every register updates on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
temp_in  in  WIDTH  temperature code from temp_to_dig
temp_valid  in  1  temp_in is valid this cycle; may be high every cycle
thr_hi  in  WIDTH  alarm assert threshold (strict >)
thr_lo  in  WIDTH  alarm release threshold (strict <)
clr_minmax  in  1  one-cycle request to clear min/max trackers
avg_out  out  WIDTH  most recent window average
avg_valid  out  1  one-cycle pulse when avg_out updates
alarm  out  1  over-temperature flag
temp_max  out  WIDTH  largest avg_out since reset or clear
temp_min  out  WIDTH  smallest avg_out since reset or clear

Behaviour:
- Reset (reset=0 at a clock edge):
  - avg_out=0, avg_valid=0, alarm=0, temp_max=0, temp_min=all-ones.
  - Accumulator, sample counter and persistence counter are set to 0.
  - Alarm FSM goes to NORMAL.
  - A partial window is discarded.
- Averaging:
  - Windows are non-overlapping blocks, not a sliding average.
  - Accumulator width is WIDTH+AVG_LOG2 bits, so it cannot overflow.
  - Samples are summed only on cycles with temp_valid=1. A counter tracks samples in the current window.
  - On the 2^AVG_LOG2-th sample, avg_out <= (sum + current sample) >> AVG_LOG2, truncating.
  - avg_valid pulses in the same cycle avg_out updates: the cycle after that sample's edge. That is 1-cycle latency from the last valid sample.
  - The accumulator restarts at 0 with no dead cycle, so back-to-back windows are supported.
  - Gaps in temp_valid pause the window; the count is not reset.
- Alarm FSM: states NORMAL, PENDING, ALARM. It evaluates only in cycles where avg_valid=1. The alarm output is registered and changes one cycle after the evaluating avg_valid.
  - NORMAL:
    - avg_out > thr_hi: set cnt=1.
      - If ALARM_CNT=1, go to ALARM.
      - Otherwise go to PENDING.
    - Any other value: stay in NORMAL.
  - PENDING:
    - avg_out > thr_hi: cnt++. When cnt reaches ALARM_CNT, go to ALARM (alarm=1).
    - avg_out <= thr_hi: go to NORMAL and set cnt=0.
  - ALARM:
    - avg_out < thr_lo: go to NORMAL (alarm=0) and set cnt=0.
    - Otherwise: stay in ALARM.
  - Misconfiguration (thr_lo > thr_hi) is not an error. The rules above apply literally.
  - Thresholds are sampled at each evaluation and may change at any time.
- Min/max tracking:
  - On avg_valid: temp_max <= max(temp_max, avg_out) and temp_min <= min(temp_min, avg_out), evaluated on the new avg_out value.
  - clr_minmax=1: temp_max <= 0 and temp_min <= all-ones on the next edge.
  - If clr_minmax coincides with an avg_valid update, clear wins and that average is not recorded.
  - clr_minmax does not affect averaging or alarm.
- Reset has priority over all other inputs.

Decomposition:
- Package temp_pkg holds:
  - alarm FSM state encoding (NORMAL=2'd0, PENDING=2'd1, ALARM=2'd2);
  - default WIDTH/AVG_LOG2/ALARM_CNT constants;
  - localparam ACC_W = WIDTH+AVG_LOG2.
- Sub-module temp_avg contains the accumulator, sample counter and avg_out/avg_valid.
- temp_monitor instantiates temp_avg and contains the alarm FSM and min/max logic.

Test Plan:
1. Reset held 2 cycles, then released with no temp_valid -> avg_out=0, avg_valid=0, alarm=0, temp_max=0, temp_min=255.
2. Samples 10,11,12,13 with temp_valid on consecutive cycles -> avg_valid pulses once, one cycle after the sample-13 edge, with avg_out=11 (46>>2).
3. Persistence filter, thr_hi=100, thr_lo=90:
   - three windows of all-120 -> alarm=1 one cycle after the third avg_valid;
   - separately: 120, 120, then a 95 window -> alarm stays 0 throughout.
4. Hysteresis, from the alarm state of scenario 3 with thr_hi=100, thr_lo=90:
   - window average 95 -> alarm stays 1;
   - next window average 80 -> alarm=0 one cycle after that avg_valid.
5. Reset mid-window:
   - two samples of 200, then reset=0 for 1 cycle, then four samples of 20 -> single avg_valid with avg_out=20;
   - temp_valid with gaps of 3 idle cycles between samples gives the same result.
6. Min/max and clear:
   - window averages 50, 30, 70 -> temp_max=70, temp_min=30;
   - then clr_minmax asserted in the same cycle as the next window's last sample edge (coincident with avg_valid) -> temp_max=0, temp_min=255.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared constants for the temperature monitor: default sizing and the
// alarm FSM state encoding.
package temp_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_AVG_LOG2  = 2;
  localparam int DEF_ALARM_CNT = 3;
  localparam int ACC_W         = DEF_WIDTH + DEF_AVG_LOG2;

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_ALARM   = 2'd2;

endpackage

// File: rtl/temp_avg.sv
// Non-overlapping block averager: sums 2^AVG_LOG2 valid samples and emits
// their truncated mean, restarting with no dead cycle between windows.
module temp_avg
  import temp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] temp_in,
  input  logic             temp_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic [WIDTH-1:0] avg_next,
  output logic             avg_done
);

  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] sample_cnt;

  assign sum      = acc + {{AVG_LOG2{1'b0}}, temp_in};
  assign avg_next = sum[SUM_W-1:AVG_LOG2];
  // avg_done/avg_next let the parent act on the average at the same edge it lands in avg_out
  assign avg_done = temp_valid && (sample_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= avg_done;
      if (avg_done) begin
        acc        <= '0;
        sample_cnt <= '0;
        avg_out    <= avg_next;
      end else if (temp_valid) begin
        acc        <= sum;
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/temp_monitor.sv
// Temperature monitor: block averaging, min/max tracking of the averages and
// an over-temperature alarm with hysteresis and a persistence filter.
module temp_monitor
  import temp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int AVG_LOG2  = DEF_AVG_LOG2,
  parameter int ALARM_CNT = DEF_ALARM_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] temp_in,
  input  logic             temp_valid,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic             clr_minmax,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             alarm,
  output logic [WIDTH-1:0] temp_max,
  output logic [WIDTH-1:0] temp_min
);

  localparam logic [3:0] CNT_TARGET = 4'(ALARM_CNT);

  logic [WIDTH-1:0] avg_next;
  logic             avg_done;
  logic [1:0]       state;
  logic [3:0]       persist_cnt;
  logic [3:0]       persist_inc;

  temp_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk        (clk),
    .reset      (reset),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_next   (avg_next),
    .avg_done   (avg_done)
  );

  assign persist_inc = persist_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_NORMAL;
      persist_cnt <= '0;
      alarm       <= 1'b0;
    end else if (avg_valid) begin
      case (state)
        ST_NORMAL: begin
          if (avg_out > thr_hi) begin
            persist_cnt <= 4'd1;
            if (ALARM_CNT == 1) begin
              state <= ST_ALARM;
              alarm <= 1'b1;
            end else begin
              state <= ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          if (avg_out > thr_hi) begin
            persist_cnt <= persist_inc;
            if (persist_inc == CNT_TARGET) begin
              state <= ST_ALARM;
              alarm <= 1'b1;
            end
          end else begin
            state       <= ST_NORMAL;
            persist_cnt <= '0;
          end
        end
        ST_ALARM: begin
          // Release uses the lower threshold so the flag does not chatter near thr_hi
          if (avg_out < thr_lo) begin
            state       <= ST_NORMAL;
            persist_cnt <= '0;
            alarm       <= 1'b0;
          end
        end
        default: begin
          state       <= ST_NORMAL;
          persist_cnt <= '0;
          alarm       <= 1'b0;
        end
      endcase
    end
  end

  // Trackers follow the average being written this edge, so a coincident clear drops it
  always_ff @(posedge clk) begin
    if (!reset) begin
      temp_max <= '0;
      temp_min <= '1;
    end else if (clr_minmax) begin
      temp_max <= '0;
      temp_min <= '1;
    end else if (avg_done) begin
      if (avg_next > temp_max) temp_max <= avg_next;
      if (avg_next < temp_min) temp_min <= avg_next;
    end
  end

endmodule

// File: tb/tb_temp_monitor.sv
// Directed self-checking bench for temp_monitor with hand-computed expectations.
module tb_temp_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic [7:0] thr_hi;
  logic [7:0] thr_lo;
  logic       clr_minmax;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       alarm;
  logic [7:0] temp_max;
  logic [7:0] temp_min;

  int tests_run;
  int tests_failed;

  temp_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .clr_minmax (clr_minmax),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .alarm      (alarm),
    .temp_max   (temp_max),
    .temp_min   (temp_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, then settle for checking
  task automatic applyStimulus(input logic valid, input logic [7:0] value);
    temp_valid = valid;
    temp_in    = value;
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic windowOf(input string tag, input logic [7:0] value);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, value);
    checkOutput({tag, "_valid"}, 32'(avg_valid), 32'd1);
    checkOutput({tag, "_avg"}, 32'(avg_out), 32'(value));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    temp_in      = '0;
    temp_valid   = 1'b0;
    thr_hi       = 8'd100;
    thr_lo       = 8'd90;
    clr_minmax   = 1'b0;

    // Reset and idle
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0);
    checkOutput("rst_avg", 32'(avg_out), 32'd0);
    checkOutput("rst_valid", 32'(avg_valid), 32'd0);
    checkOutput("rst_alarm", 32'(alarm), 32'd0);
    checkOutput("rst_max", 32'(temp_max), 32'd0);
    checkOutput("rst_min", 32'(temp_min), 32'd255);

    // 10,11,12,13 -> 46>>2 = 11
    applyStimulus(1'b1, 8'd10);
    checkOutput("w1_s1_valid", 32'(avg_valid), 32'd0);
    applyStimulus(1'b1, 8'd11);
    applyStimulus(1'b1, 8'd12);
    checkOutput("w1_s3_valid", 32'(avg_valid), 32'd0);
    applyStimulus(1'b1, 8'd13);
    checkOutput("w1_valid", 32'(avg_valid), 32'd1);
    checkOutput("w1_avg", 32'(avg_out), 32'd11);
    applyStimulus(1'b0, 8'd0);
    checkOutput("w1_pulse_end", 32'(avg_valid), 32'd0);
    checkOutput("w1_max", 32'(temp_max), 32'd11);
    checkOutput("w1_min", 32'(temp_min), 32'd11);

    // Persistence: three windows above thr_hi raise alarm
    windowOf("p1", 8'd120);
    applyStimulus(1'b0, 8'd0);
    checkOutput("p1_alarm", 32'(alarm), 32'd0);
    windowOf("p2", 8'd120);
    applyStimulus(1'b0, 8'd0);
    checkOutput("p2_alarm", 32'(alarm), 32'd0);
    windowOf("p3", 8'd120);
    checkOutput("p3_alarm_same", 32'(alarm), 32'd0);
    applyStimulus(1'b0, 8'd0);
    checkOutput("p3_alarm", 32'(alarm), 32'd1);

    // Hysteresis: 95 holds, 80 releases
    windowOf("h1", 8'd95);
    applyStimulus(1'b0, 8'd0);
    checkOutput("h1_alarm", 32'(alarm), 32'd1);
    windowOf("h2", 8'd80);
    checkOutput("h2_alarm_same", 32'(alarm), 32'd1);
    applyStimulus(1'b0, 8'd0);
    checkOutput("h2_alarm", 32'(alarm), 32'd0);

    // Broken run: 120,120,95 never alarms and restarts the count
    windowOf("b1", 8'd120);
    applyStimulus(1'b0, 8'd0);
    windowOf("b2", 8'd120);
    applyStimulus(1'b0, 8'd0);
    windowOf("b3", 8'd95);
    applyStimulus(1'b0, 8'd0);
    checkOutput("b3_alarm", 32'(alarm), 32'd0);
    windowOf("b4", 8'd120);
    applyStimulus(1'b0, 8'd0);
    windowOf("b5", 8'd120);
    applyStimulus(1'b0, 8'd0);
    checkOutput("b5_alarm", 32'(alarm), 32'd0);
    windowOf("b6", 8'd120);
    applyStimulus(1'b0, 8'd0);
    checkOutput("b6_alarm", 32'(alarm), 32'd1);
    checkOutput("b6_max", 32'(temp_max), 32'd120);
    checkOutput("b6_min", 32'(temp_min), 32'd11);

    // Reset mid-window discards the partial sum
    applyStimulus(1'b1, 8'd200);
    applyStimulus(1'b1, 8'd200);
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0);
    reset = 1'b1;
    checkOutput("mr_alarm", 32'(alarm), 32'd0);
    checkOutput("mr_avg", 32'(avg_out), 32'd0);
    checkOutput("mr_max", 32'(temp_max), 32'd0);
    checkOutput("mr_min", 32'(temp_min), 32'd255);
    applyStimulus(1'b1, 8'd20);
    applyStimulus(1'b1, 8'd20);
    checkOutput("mr_s2_valid", 32'(avg_valid), 32'd0);
    applyStimulus(1'b1, 8'd20);
    applyStimulus(1'b1, 8'd20);
    checkOutput("mr_valid", 32'(avg_valid), 32'd1);
    checkOutput("mr_avg20", 32'(avg_out), 32'd20);

    // Gapped samples pause the window without resetting it
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 8'd20);
      checkOutput("gap_valid", 32'(avg_valid), (s == 3) ? 32'd1 : 32'd0);
      if (s < 3) begin
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 8'd0);
      end
    end
    checkOutput("gap_avg", 32'(avg_out), 32'd20);

    // Min/max after an explicit clear
    clr_minmax = 1'b1;
    applyStimulus(1'b0, 8'd0);
    clr_minmax = 1'b0;
    checkOutput("clr_max", 32'(temp_max), 32'd0);
    checkOutput("clr_min", 32'(temp_min), 32'd255);
    windowOf("m1", 8'd50);
    windowOf("m2", 8'd30);
    windowOf("m3", 8'd70);
    applyStimulus(1'b0, 8'd0);
    checkOutput("m_max", 32'(temp_max), 32'd70);
    checkOutput("m_min", 32'(temp_min), 32'd30);
    checkOutput("m_alarm", 32'(alarm), 32'd0);

    // Clear coincident with the window completion wins
    applyStimulus(1'b1, 8'd60);
    applyStimulus(1'b1, 8'd60);
    applyStimulus(1'b1, 8'd60);
    clr_minmax = 1'b1;
    applyStimulus(1'b1, 8'd60);
    clr_minmax = 1'b0;
    checkOutput("cc_valid", 32'(avg_valid), 32'd1);
    checkOutput("cc_avg", 32'(avg_out), 32'd60);
    applyStimulus(1'b0, 8'd0);
    checkOutput("cc_max", 32'(temp_max), 32'd0);
    checkOutput("cc_min", 32'(temp_min), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
